// File: rtl/p2s_multilane_converter.sv
// Parallel-to-serial converter: buffers N-bit words and emits each as W-bit beats.
// Latency: a word pushed into an empty block at edge t is presented after edge t+1.
// Backpressure: par_ready drops when the input FIFO is full; the shifter holds while ser_ready=0.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   par_data/valid/ready      N-bit word input; par_ready is registered (= FIFO not full)
//   ser_data/valid/ready      W-bit beat output
//   ser_last                  marks the final beat of each word
//   busy                      FIFO non-empty or shifter loaded
// Optional feature: define P2S_PARITY_EN to append an even-parity beat to every word.

// Generic FIFO: holds DEPTH words between a producer and a consumer.
// Latency: a pushed word is visible at pop_dat after the push edge.
// Backpressure: push_rdy is registered and low when full; no pass-through on a full FIFO.
module p2s_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;
    logic             push;
    logic             pop;

    assign push       = push_vld && push_rdy;
    assign pop        = pop_vld && pop_rdy;
    assign pop_vld    = (wr_ptr != rd_ptr);
    assign pop_dat    = mem[rd_ptr[AW-1:0]];
    assign wr_ptr_nxt = wr_ptr + PW'(push);
    assign rd_ptr_nxt = rd_ptr + PW'(pop);

    // Ready is registered from the next-cycle occupancy, so a pop never frees
    // a slot for a push on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            push_rdy <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            push_rdy <= ((wr_ptr_nxt - rd_ptr_nxt) != PW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end
endmodule

// Word-to-beat serializer with an input FIFO of DEPTH words (DEPTH+1 words total storage).
// Latency: push at edge t into an empty block gives ser_valid=1 after edge t+1.
// Backpressure: beats advance only on ser_valid && ser_ready; par_ready = !full, registered.
module p2s_multilane_converter #(
    parameter int N         = 8,
    parameter int W         = 1,
    parameter int DEPTH     = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] par_data,
    input  logic         par_valid,
    output logic         par_ready,
    output logic [W-1:0] ser_data,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         ser_last,
    output logic         busy
);
    localparam int NB = N / W;
`ifdef P2S_PARITY_EN
    localparam int BEATS = NB + 1;
`else
    localparam int BEATS = NB;
`endif
    localparam int CW = $clog2(BEATS);

    // The load step is the IDLE->SHIFT transition itself, so it costs no extra cycle.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]    state;
    logic [N-1:0]  word_q;
    logic [CW-1:0] cnt;
    logic          fifo_vld;
    logic [N-1:0]  fifo_dat;
    logic          beat_fire;
    logic          last_beat;
    logic          shifter_free;
    logic          load;
    logic [CW-1:0] slice_idx;
    logic [W-1:0]  slice_dat;

    p2s_fifo #(
        .WIDTH (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (par_valid),
        .push_rdy (par_ready),
        .push_dat (par_data),
        .pop_vld  (fifo_vld),
        .pop_rdy  (shifter_free),
        .pop_dat  (fifo_dat)
    );

    assign ser_valid = (state == ST_SHIFT);
    assign last_beat = (cnt == CW'(BEATS - 1));
    assign beat_fire = ser_valid && ser_ready;
    // Shifter can take a new word when idle or when its final beat leaves this edge,
    // which is what keeps back-to-back words gap-free.
    assign shifter_free = (state == ST_IDLE) || (beat_fire && last_beat);
    assign load         = fifo_vld && shifter_free;
    assign ser_last     = ser_valid && last_beat;
    assign busy         = fifo_vld || ser_valid;

    // Beat k maps to slice NB-1-k (MSB first) or slice k (LSB first) of the word.
    assign slice_idx = (MSB_FIRST != 0) ? (CW'(NB - 1) - cnt) : cnt;
    assign slice_dat = word_q[slice_idx*W +: W];

    always_comb begin
        ser_data = '0;
        if (ser_valid) begin
`ifdef P2S_PARITY_EN
            if (last_beat) begin
                ser_data[0] = ^word_q;
            end else begin
                ser_data = slice_dat;
            end
`else
            ser_data = slice_dat;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            word_q <= '0;
            cnt    <= '0;
        end else if (load) begin
            state  <= ST_SHIFT;
            word_q <= fifo_dat;
            cnt    <= '0;
        end else if (beat_fire) begin
            if (last_beat) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_p2s_multilane_converter.sv
module tb_p2s_multilane_converter;
`ifdef P2S_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int WA = 1;
    localparam int MA = 1;
    localparam int DA = 2;
    localparam int WB = 2;
    localparam int MB = 0;
    localparam int DB = 4;
    localparam int BEATS_A = 8 / WA + PAR;
    localparam int BEATS_B = 8 / WB + PAR;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    par_data_a, par_data_b;
    logic          par_valid_a, par_valid_b;
    logic          par_ready_a, par_ready_b;
    logic [WA-1:0] ser_data_a;
    logic [WB-1:0] ser_data_b;
    logic          ser_valid_a, ser_valid_b;
    logic          ser_ready_a, ser_ready_b;
    logic          ser_last_a, ser_last_b;
    logic          busy_a, busy_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];
    logic [8:0] e_a, e_b;

    always #5 clk = ~clk;

    p2s_multilane_converter #(.N(8), .W(WA), .DEPTH(DA), .MSB_FIRST(MA)) dut_a (
        .clk(clk), .rst(rst), .par_data(par_data_a), .par_valid(par_valid_a),
        .par_ready(par_ready_a), .ser_data(ser_data_a), .ser_valid(ser_valid_a),
        .ser_ready(ser_ready_a), .ser_last(ser_last_a), .busy(busy_a));

    p2s_multilane_converter #(.N(8), .W(WB), .DEPTH(DB), .MSB_FIRST(MB)) dut_b (
        .clk(clk), .rst(rst), .par_data(par_data_b), .par_valid(par_valid_b),
        .par_ready(par_ready_b), .ser_data(ser_data_b), .ser_valid(ser_valid_b),
        .ser_ready(ser_ready_b), .ser_last(ser_last_b), .busy(busy_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference beat k of word w for lane width wl: {last, data}.
    function automatic logic [8:0] beat_of(input logic [7:0] w, input int wl, input int msb, input int k);
        int         nb;
        logic [7:0] mask;
        logic [7:0] d;
        nb   = 8 / wl;
        mask = 8'((1 << wl) - 1);
        if (k >= nb)
            d = {7'b0, ^w};
        else if (msb != 0)
            d = (w >> (8 - (k + 1) * wl)) & mask;
        else
            d = (w >> (k * wl)) & mask;
        return {(k == nb - 1 + PAR), d};
    endfunction

    // Scoreboards: sampled on the falling edge, i.e. the values the next rising edge will use.
    always @(negedge clk) begin
        if (rst) begin
            exp_a.delete();
        end else begin
            if (ser_valid_a && ser_ready_a) begin
                check("a_beat_expected", 32'(exp_a.size() > 0), 1);
                if (exp_a.size() > 0) begin
                    e_a = exp_a.pop_front();
                    check("a_beat_data", 32'(ser_data_a), 32'(e_a[7:0]));
                    check("a_beat_last", 32'(ser_last_a), 32'(e_a[8]));
                end
            end
            if (par_valid_a && par_ready_a)
                for (int k = 0; k < BEATS_A; k++) exp_a.push_back(beat_of(par_data_a, WA, MA, k));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_b.delete();
        end else begin
            if (ser_valid_b && ser_ready_b) begin
                check("b_beat_expected", 32'(exp_b.size() > 0), 1);
                if (exp_b.size() > 0) begin
                    e_b = exp_b.pop_front();
                    check("b_beat_data", 32'(ser_data_b), 32'(e_b[7:0]));
                    check("b_beat_last", 32'(ser_last_b), 32'(e_b[8]));
                end
            end
            if (par_valid_b && par_ready_b)
                for (int k = 0; k < BEATS_B; k++) exp_b.push_back(beat_of(par_data_b, WB, MB, k));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a(input int bound);
        for (int i = 0; i < bound && (busy_a || exp_a.size() != 0); i++) step();
        check("a_drained", 32'(exp_a.size()), 0);
        check("a_idle_busy", 32'(busy_a), 0);
    endtask

    task automatic wait_idle_b(input int bound);
        for (int i = 0; i < bound && (busy_b || exp_b.size() != 0); i++) step();
        check("b_drained", 32'(exp_b.size()), 0);
        check("b_idle_busy", 32'(busy_b), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         gaps;
        logic [8:0] held;

        rst = 1'b1;
        par_data_a = '0; par_valid_a = 1'b0; ser_ready_a = 1'b0;
        par_data_b = '0; par_valid_b = 1'b0; ser_ready_b = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_ser_valid_a", 32'(ser_valid_a), 0);
        check("rst_ser_data_a", 32'(ser_data_a), 0);
        check("rst_ser_last_a", 32'(ser_last_a), 0);
        check("rst_busy_a", 32'(busy_a), 0);
        check("rst_par_ready_a", 32'(par_ready_a), 0);
        check("rst_ser_valid_b", 32'(ser_valid_b), 0);
        check("rst_busy_b", 32'(busy_b), 0);
        check("rst_par_ready_b", 32'(par_ready_b), 0);
        rst = 1'b0;
        step();
        check("post_rst_par_ready_a", 32'(par_ready_a), 1);
        check("post_rst_par_ready_b", 32'(par_ready_b), 1);

        // W=1 MSB first, 0xB4, with first-beat latency
        ser_ready_a = 1'b1;
        par_data_a = 8'hB4; par_valid_a = 1'b1;
        step();
        par_valid_a = 1'b0;
        check("lat_valid_after_push", 32'(ser_valid_a), 0);
        check("lat_busy_after_push", 32'(busy_a), 1);
        step();
        check("lat_valid_after_load", 32'(ser_valid_a), 1);
        check("b4_first_beat", 32'(ser_data_a), 1);
        wait_idle_a(40);

        // W=2 LSB first, 0xB4 -> 00,01,11,10
        ser_ready_b = 1'b1;
        par_data_b = 8'hB4; par_valid_b = 1'b1;
        step();
        par_valid_b = 1'b0;
        step();
        check("b_b4_beat0", 32'(ser_data_b), 32'h0);
        step();
        check("b_b4_beat1", 32'(ser_data_b), 32'h1);
        step();
        check("b_b4_beat2", 32'(ser_data_b), 32'h3);
        wait_idle_b(40);

        par_data_a = 8'hB5; par_valid_a = 1'b1;
        step();
        par_valid_a = 1'b0;
        wait_idle_a(40);

        // Back-to-back words with no bubble
        par_data_a = 8'hA5; par_valid_a = 1'b1;
        step();
        par_data_a = 8'h3C;
        step();
        par_valid_a = 1'b0;
        gaps = 0;
        repeat (2 * BEATS_A) begin
            if (!ser_valid_a) gaps++;
            step();
        end
        check("b2b_gap_cycles", 32'(gaps), 0);
        check("b2b_valid_after", 32'(ser_valid_a), 0);
        wait_idle_a(10);

        // Stall mid-word after three beats
        par_data_a = 8'hA5; par_valid_a = 1'b1;
        step();
        par_valid_a = 1'b0;
        repeat (4) step();
        ser_ready_a = 1'b0;
        held = beat_of(8'hA5, WA, MA, 3);
        repeat (3) begin
            step();
            check("stall_valid", 32'(ser_valid_a), 1);
            check("stall_data", 32'(ser_data_a), 32'(held[7:0]));
            check("stall_last", 32'(ser_last_a), 0);
        end
        ser_ready_a = 1'b1;
        wait_idle_a(40);

        // Fill FIFO plus shifter, then block a 4th word
        ser_ready_a = 1'b0;
        par_valid_a = 1'b1;
        par_data_a = 8'h11; step();
        par_data_a = 8'h22; step();
        par_data_a = 8'h33; step();
        check("full_par_ready", 32'(par_ready_a), 0);
        par_data_a = 8'h44;
        repeat (3) step();
        check("full_still_blocked", 32'(par_ready_a), 0);
        ser_ready_a = 1'b1;
        repeat (BEATS_A - 1) step();
        check("full_before_drain", 32'(par_ready_a), 0);
        step();
        check("full_after_drain", 32'(par_ready_a), 1);
        step();
        par_valid_a = 1'b0;
        wait_idle_a(5 * BEATS_A + 10);

        // Reset in the middle of a word with another word buffered
        par_valid_a = 1'b1;
        par_data_a = 8'hFF; step();
        par_data_a = 8'h77; step();
        par_valid_a = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        #1;
        check("midrst_ser_valid", 32'(ser_valid_a), 0);
        check("midrst_busy", 32'(busy_a), 0);
        check("midrst_ser_data", 32'(ser_data_a), 0);
        check("midrst_par_ready", 32'(par_ready_a), 0);
        step();
        rst = 1'b0;
        step();
        check("postrst_busy", 32'(busy_a), 0);
        check("postrst_par_ready", 32'(par_ready_a), 1);
        par_data_a = 8'h01; par_valid_a = 1'b1;
        step();
        par_valid_a = 1'b0;
        step();
        check("postrst_first_beat", 32'(ser_data_a), 0);
        wait_idle_a(40);

        // Randomized traffic on both instances against the reference model
        for (int c = 0; c < 800; c++) begin
            par_valid_a = ($urandom_range(0, 2) != 0);
            par_data_a  = 8'($urandom);
            ser_ready_a = ($urandom_range(0, 3) != 0);
            par_valid_b = ($urandom_range(0, 2) != 0);
            par_data_b  = 8'($urandom);
            ser_ready_b = ($urandom_range(0, 3) != 0);
            step();
        end
        par_valid_a = 1'b0; par_valid_b = 1'b0;
        ser_ready_a = 1'b1; ser_ready_b = 1'b1;
        wait_idle_a(10 * BEATS_A + 20);
        wait_idle_b(10 * BEATS_B + 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
